// File: rtl/fpu_norm_pkg.sv
// ============================================================================
// Module      : fpu_norm_pkg
// Description : Shared types and constants for the exponent/significand
//               normalize/denormalize sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_norm_pkg;

  localparam int EXP_W  = 13;
  localparam int FRAC_W = 56;

  localparam logic signed [EXP_W-1:0] EMIN         = 13'sd1;
  localparam logic signed [EXP_W-1:0] ALPHA_SGL    = 13'sd192;
  localparam logic signed [EXP_W-1:0] ALPHA_DBL    = 13'sd1536;
  localparam logic signed [EXP_W-1:0] DENORM_CLAMP = -13'sd56;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORM   = 2'd1,
    DENORM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/norm_denorm_seq.sv
// ============================================================================
// Module      : norm_denorm_seq
// Description : Multi-cycle normalizer/denormalizer, one bit shift per cycle,
//               with underflow trap exponent wrap and sticky-bit tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_denorm_seq
  import fpu_norm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [EXP_W-1:0]  e_in,
  input  logic        [FRAC_W-1:0] f_in,
  input  logic                     db,
  input  logic                     UNFen,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [EXP_W-1:0]  e_out,
  output logic        [FRAC_W-1:0] f_out,
  output logic                     tiny,
  output logic                     unf,
  output logic                     zero
);

  state_t                    r_state;
  state_t                    w_next;
  logic signed [EXP_W-1:0]   r_e;
  logic        [FRAC_W-1:0]  r_f;
  logic                      r_db;
  logic                      r_unfen;
  logic                      r_tiny;
  logic                      r_unf;
  logic                      r_zero;

  logic                      w_in_zero;
  logic                      w_lead0;
  logic                      w_norm_shift;
  logic                      w_below;
  logic                      w_clamp;
  logic                      w_denorm_last;
  logic signed [EXP_W-1:0]   w_e_inc;
  logic signed [EXP_W-1:0]   w_alpha;

  assign w_in_zero     = (f_in == '0);
  assign w_lead0       = ~r_f[FRAC_W-1];
  // A zero operand still passes through NORM so its latency matches a normal one.
  assign w_norm_shift  = !r_zero && w_lead0 && (r_unfen || (r_e > EMIN));
  assign w_below       = (r_e < EMIN);
  assign w_clamp       = (r_e < DENORM_CLAMP);
  assign w_e_inc       = r_e + 13'sd1;
  assign w_denorm_last = (w_e_inc == EMIN);
  assign w_alpha       = r_db ? ALPHA_DBL : ALPHA_SGL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_next = NORM;
      end
      NORM: begin
        if (r_zero)                  w_next = DONE;
        else if (w_norm_shift)       w_next = NORM;
        else if (w_below && !r_unfen) w_next = DENORM;
        else                         w_next = DONE;
      end
      DENORM: begin
        if (w_clamp || w_denorm_last) w_next = DONE;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (r_state == IDLE) in_ready  = 1'b1;
    if (r_state == DONE) out_valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e     <= '0;
      r_f     <= '0;
      r_db    <= 1'b0;
      r_unfen <= 1'b0;
      r_tiny  <= 1'b0;
      r_unf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_e     <= w_in_zero ? '0 : e_in;
            r_f     <= f_in;
            r_db    <= db;
            r_unfen <= UNFen;
            r_tiny  <= 1'b0;
            r_unf   <= 1'b0;
            r_zero  <= w_in_zero;
          end
        end
        NORM: begin
          if (!r_zero) begin
            if (w_norm_shift) begin
              r_f <= {r_f[FRAC_W-2:0], 1'b0};
              r_e <= r_e - 13'sd1;
            end else if (w_below) begin
              if (r_unfen) begin
                r_e    <= r_e + w_alpha;
                r_tiny <= 1'b1;
                r_unf  <= 1'b1;
              end
            end else if (w_lead0) begin
              // Halted at EMIN with the hidden bit clear: result is denormal.
              r_tiny <= 1'b1;
            end
          end
        end
        DENORM: begin
          r_tiny <= 1'b1;
          if (w_clamp) begin
            r_f   <= {{(FRAC_W-1){1'b0}}, |r_f};
            r_e   <= EMIN;
            r_unf <= r_unf | (|r_f);
          end else begin
            // Bit 0 is the sticky position; a 1 leaving it makes the result inexact.
            r_f   <= {1'b0, r_f[FRAC_W-1:2], r_f[1] | r_f[0]};
            r_e   <= w_e_inc;
            r_unf <= r_unf | r_f[0];
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign e_out = r_e;
  assign f_out = r_f;
  assign tiny  = r_tiny;
  assign unf   = r_unf;
  assign zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_norm_denorm_seq.sv
// ============================================================================
// Module      : tb_norm_denorm_seq
// Description : Scoreboard bench for norm_denorm_seq with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_norm_denorm_seq;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [12:0]  e_in;
  logic        [55:0]  f_in;
  logic                db;
  logic                UNFen;
  logic                out_valid;
  logic                out_ready;
  logic signed [12:0]  e_out;
  logic        [55:0]  f_out;
  logic                tiny;
  logic                unf;
  logic                zero;

  typedef struct {
    logic signed [12:0] e;
    logic        [55:0] f;
    logic               t;
    logic               u;
    logic               z;
    int                 due;
    int                 id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   vec_id = 0;
  logic prev_valid = 1'b0;
  exp_t hd;

  norm_denorm_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e_in      (e_in),
    .f_in      (f_in),
    .db        (db),
    .UNFen     (UNFen),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e_out     (e_out),
    .f_out     (f_out),
    .tiny      (tiny),
    .unf       (unf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks the queue head on every valid cycle, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got e=%0d f=%h, required no output", e_out, f_out);
      end else begin
        hd = exp_q[0];
        if (!prev_valid) begin
          n_cmp++;
          if (cyc != hd.due) begin
            n_bad++;
            $display("FAIL vec%0d_latency: got cycle %0d, required cycle %0d", hd.id, cyc, hd.due);
          end
        end
        n_cmp++;
        if ({e_out, f_out, tiny, unf, zero} !== {hd.e, hd.f, hd.t, hd.u, hd.z}) begin
          n_bad++;
          $display("FAIL vec%0d_result: got e=%0d f=%h tiny=%b unf=%b zero=%b, required e=%0d f=%h tiny=%b unf=%b zero=%b",
                   hd.id, e_out, f_out, tiny, unf, zero, hd.e, hd.f, hd.t, hd.u, hd.z);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    prev_valid = rst_n && out_valid;
  end

  // Called one time unit after a rising edge with the block idle.
  task automatic drive(input logic [55:0] f, input logic signed [12:0] e, input logic d,
                       input logic u, input logic signed [12:0] xe, input logic [55:0] xf,
                       input logic xt, input logic xu, input logic xz, input int lat);
    exp_t x;
    x.e = xe; x.f = xf; x.t = xt; x.u = xu; x.z = xz;
    x.due = cyc + lat; x.id = vec_id;
    vec_id++;
    exp_q.push_back(x);
    in_valid = 1'b1; f_in = f; e_in = e; db = d; UNFen = u;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [55:0] f, input logic signed [12:0] e, input logic d,
                      input logic u, input logic signed [12:0] xe, input logic [55:0] xf,
                      input logic xt, input logic xu, input logic xz, input int lat);
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=%b, required 1", in_ready);
    end else begin
      drive(f, e, d, u, xe, xf, xt, xu, xz, lat);
    end
  endtask

  task automatic check_reset(input int tag);
    n_cmp++;
    if ({out_valid, in_ready, e_out, f_out, tiny, unf, zero} !== {1'b0, 1'b1, 13'd0, 56'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset%0d: got out_valid=%b in_ready=%b e=%0d f=%h flags=%b%b%b, required out_valid=0 in_ready=1 all zero",
               tag, out_valid, in_ready, e_out, f_out, tiny, unf, zero);
    end
  endtask

  localparam logic [55:0] H = 56'h80_0000_0000_0000;

  initial begin
    int w;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    e_in = '0; f_in = '0; db = 1'b0; UNFen = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset(0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // accepted on the very first edge after release
    drive(H, 13'sd100, 1'b1, 1'b0, 13'sd100, H, 1'b0, 1'b0, 1'b0, 2);
    send(H >> 3, 13'sd100, 1'b1, 1'b0, 13'sd97, H, 1'b0, 1'b0, 1'b0, 5);
    send(H | 56'd1, -13'sd2, 1'b1, 1'b0, 13'sd1, (H >> 3) | 56'd1, 1'b1, 1'b1, 1'b0, 5);
    send(H, -13'sd2, 1'b1, 1'b0, 13'sd1, H >> 3, 1'b1, 1'b0, 1'b0, 5);
    send(H, -13'sd10, 1'b0, 1'b1, 13'sd182, H, 1'b1, 1'b1, 1'b0, 2);
    send(H, -13'sd10, 1'b1, 1'b1, 13'sd1526, H, 1'b1, 1'b1, 1'b0, 2);
    send(56'd0, 13'sd55, 1'b1, 1'b1, 13'sd0, 56'd0, 1'b0, 1'b0, 1'b1, 2);
    send(H, -13'sd100, 1'b1, 1'b0, 13'sd1, 56'd1, 1'b1, 1'b1, 1'b0, 3);
    send(H, -13'sd57, 1'b0, 1'b0, 13'sd1, 56'd1, 1'b1, 1'b1, 1'b0, 3);
    send(H, -13'sd56, 1'b0, 1'b0, 13'sd1, 56'd1, 1'b1, 1'b1, 1'b0, 59);
    send(H >> 3, 13'sd3, 1'b1, 1'b0, 13'sd1, H >> 1, 1'b1, 1'b0, 1'b0, 4);
    send(H >> 1, 13'sd1, 1'b0, 1'b1, 13'sd192, H, 1'b1, 1'b1, 1'b0, 3);
    send(H | 56'd2, -13'sd1, 1'b1, 1'b0, 13'sd1, (H >> 2) | 56'd1, 1'b1, 1'b1, 1'b0, 4);

    // in_valid while busy must be ignored
    send(H >> 15, 13'sd100, 1'b1, 1'b0, 13'sd85, H, 1'b0, 1'b0, 1'b0, 17);
    in_valid = 1'b1; f_in = H; e_in = 13'sd5;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;

    // backpressure: result must hold for five stalled cycles
    send(H >> 5, 13'sd200, 1'b1, 1'b0, 13'sd195, H, 1'b0, 1'b0, 1'b0, 7);
    out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;

    // reset in the middle of a long normalization
    send(56'd1, 13'sd1000, 1'b1, 1'b0, 13'sd945, H, 1'b0, 1'b0, 1'b0, 57);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset(1);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(H >> 2, 13'sd50, 1'b0, 1'b0, 13'sd48, H, 1'b0, 1'b0, 1'b0, 4);

    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
